// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants and types for the Sobel edge-magnitude stage.
//   DEF_IMG_WIDTH / DEF_IMG_HEIGHT / DEF_DWIDTH : default frame geometry and pixel width
//   MAG_WIDTH : width of the signed gradients and of the unsigned magnitude
//   SAT_MAX   : value the magnitude saturates to
//   state_e   : two-state pop/push FSM encoding
package sobel_pkg;
  localparam int DEF_IMG_WIDTH  = 720;
  localparam int DEF_IMG_HEIGHT = 540;
  localparam int DEF_DWIDTH     = 8;
  localparam int MAG_WIDTH      = 11;
  localparam int SAT_MAX        = 255;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_e;
endpackage

// File: rtl/sobel_filter_if.sv
// sobel_filter_if: FIFO-side signals of the Sobel stage.
//   in_dout/in_empty/in_rd_en    : first-word-fall-through upstream FIFO read port
//   out_din/out_full/out_wr_en   : downstream FIFO write port
//   master : the filter (pops upstream, pushes downstream)
//   slave  : the FIFO pair / environment around it
interface sobel_filter_if
  import sobel_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
);
  logic [DWIDTH-1:0] in_dout;
  logic              in_empty;
  logic              in_rd_en;
  logic [DWIDTH-1:0] out_din;
  logic              out_full;
  logic              out_wr_en;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one image row of pixels, DEPTH x DWIDTH.
//   clock_i, reset_i : clock, async active-high reset (clears contents)
//   we_i             : write enable
//   addr_i           : shared read/write address
//   wdata_i          : write data
//   rdata_o          : combinational read of the old contents at addr_i,
//                      so a same-cycle write behaves as read-then-write
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = DEF_IMG_WIDTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AW     = 10
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);
  logic [DWIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel edge magnitude, one output per input pixel.
//   clock : rising-edge clock
//   reset : async active-high reset, discards any partial frame
//   bus   : sobel_filter_if.master (upstream FIFO pop, downstream FIFO push)
// Alternates pop (S_READ) and push (S_WRITE); the output for a pixel is the
// Sobel value centred one row up and one column left, 0 on the 2-pixel border.
// Optional build macro SOBEL_THRESHOLD_EN: adds parameter THRESHOLD and turns the
// output into a binary edge map (255 when mag > THRESHOLD, else 0).
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DWIDTH     = DEF_DWIDTH
`ifdef SOBEL_THRESHOLD_EN
  , parameter int THRESHOLD = 64
`endif
) (
  input logic            clock,
  input logic            reset,
  sobel_filter_if.master bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // win[r][c]: r=0 oldest row, c=2 newest column; [1][1] is the centre
  typedef logic [2:0][2:0][DWIDTH-1:0] win_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  win_t              win_q, win_d;
  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              pop, push;
  logic [DWIDTH-1:0] top, mid;

  function automatic logic [MAG_WIDTH-1:0] sobel_mag(input win_t w);
    logic signed [MAG_WIDTH-1:0] gx, gy;
    logic [MAG_WIDTH-1:0]        ax, ay, sum;
    gx = MAG_WIDTH'((int'(w[0][2]) + 2 * int'(w[1][2]) + int'(w[2][2]))
                  - (int'(w[0][0]) + 2 * int'(w[1][0]) + int'(w[2][0])));
    gy = MAG_WIDTH'((int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2]))
                  - (int'(w[0][0]) + 2 * int'(w[0][1]) + int'(w[0][2])));
    ax  = gx[MAG_WIDTH-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[MAG_WIDTH-1] ? $unsigned(-gy) : $unsigned(gy);
    sum = ax + ay;  // at most 2040, fits MAG_WIDTH bits
    return sum >> 1;
  endfunction

  function automatic logic [DWIDTH-1:0] shade(input logic [MAG_WIDTH-1:0] m);
`ifdef SOBEL_THRESHOLD_EN
    return (int'(m) > THRESHOLD) ? DWIDTH'(SAT_MAX) : '0;
`else
    return (int'(m) > SAT_MAX) ? DWIDTH'(SAT_MAX) : m[DWIDTH-1:0];
`endif
  endfunction

  // Handshakes are gated by reset so no FIFO word is lost while held in reset.
  assign pop  = (state_q == S_READ)  && !bus.in_empty && !reset;
  assign push = (state_q == S_WRITE) && !bus.out_full && !reset;

  // lb0 holds the previous row, lb1 the one before it
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DWIDTH(DWIDTH), .AW(CW)) u_lb0 (
    .clock_i(clock), .reset_i(reset), .we_i(pop), .addr_i(col_q),
    .wdata_i(bus.in_dout), .rdata_o(mid)
  );
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DWIDTH(DWIDTH), .AW(CW)) u_lb1 (
    .clock_i(clock), .reset_i(reset), .we_i(pop), .addr_i(col_q),
    .wdata_i(mid), .rdata_o(top)
  );

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_READ;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READ:  if (pop)  state_d = S_WRITE;
      S_WRITE: if (push) state_d = S_READ;
      default: state_d = S_READ;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_rd_en  = pop;
    bus.out_wr_en = push;
    bus.out_din   = out_q;
  end

  // Datapath: window shift, raster position, registered result
  always_comb begin
    win_d   = win_q;
    valid_d = valid_q;
    col_d   = col_q;
    row_d   = row_q;
    out_d   = out_q;
    if (pop) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top;
      win_d[1][2] = mid;
      win_d[2][2] = bus.in_dout;
      // stale columns from the previous row are masked here, not cleared
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      out_d = valid_d ? shade(sobel_mag(win_d)) : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_q   <= '0;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      out_q   <= '0;
    end else begin
      win_q   <= win_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_sobel_filter.sv
// tb_sobel_filter: directed, table-driven bench for sobel_filter on an 8x6 frame.
// Each table row describes an input image, a flow-control mode and the
// hand-computed output map; hand-written sequences cover reset behaviour.
module tb_sobel_filter;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset;

  sobel_filter_if #(.DWIDTH(DW)) bus ();

  sobel_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // kind 0: two-level step along rows (on_row) or columns; kind 1: pixel = col*2
  // mode 0: free-running, 1: out_full burst of 50 cycles at output 20,
  //      2: random in_empty, 3: random in_empty and out_full
  // expected: exp_val where r>=2, c>=2 and the step coordinate is in [band_lo, band_hi]
  typedef struct {
    int    kind;
    bit    on_row;
    int    edge_at;
    int    lo;
    int    hi;
    int    mode;
    int    exp_val;
    int    band_lo;
    int    band_hi;
    string name;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix_of(input vec_t v, input int r, input int c);
    if (v.kind == 1) return c * 2;
    return ((v.on_row ? r : c) >= v.edge_at) ? v.hi : v.lo;
  endfunction

  function automatic int exp_of(input vec_t v, input int r, input int c);
    int k;
    int e;
    k = v.on_row ? r : c;
    if (r < 2 || c < 2 || k < v.band_lo || k > v.band_hi) return 0;
    e = v.exp_val;
`ifdef SOBEL_THRESHOLD_EN
    e = (e > 64) ? 255 : 0;
`endif
    return e;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int rd_cnt, wr_cnt, cyc, last_rd, stall;
    int v_rd_empty, v_both, v_wr_full, v_lat, v_stall;
    logic rd, wr;
    logic [DW-1:0] d, hold;
    logic [DW-1:0] outs [N];
    rd_cnt = 0; wr_cnt = 0; cyc = 0; last_rd = -10; stall = 0;
    v_rd_empty = 0; v_both = 0; v_wr_full = 0; v_lat = 0; v_stall = 0;
    hold = '0;
    for (int i = 0; i < N; i++) outs[i] = '0;
    while (wr_cnt < N && cyc < 4000) begin
      bus.in_dout  = (rd_cnt < N) ? DW'(pix_of(v, rd_cnt / W, rd_cnt % W)) : '0;
      bus.in_empty = (rd_cnt >= N);
      if (v.mode >= 2 && $urandom_range(0, 1) == 1) bus.in_empty = 1'b1;
      bus.out_full = 1'b0;
      if (v.mode == 1 && rd_cnt == 21 && wr_cnt == 20 && stall < 50) bus.out_full = 1'b1;
      if (v.mode == 3 && $urandom_range(0, 1) == 1) bus.out_full = 1'b1;
      #1;
      rd = bus.in_rd_en;
      wr = bus.out_wr_en;
      d  = bus.out_din;
      if (rd && bus.in_empty) v_rd_empty++;
      if (rd && wr) v_both++;
      if (wr && bus.out_full) v_wr_full++;
      if (v.mode == 1 && bus.out_full) begin
        if (stall == 0) hold = d;
        if (rd || wr || d !== hold) v_stall++;
        stall++;
      end
      if (wr && v.mode == 0 && cyc != last_rd + 1) v_lat++;
      if (wr) begin
        if (wr_cnt < N) outs[wr_cnt] = d;
        wr_cnt++;
      end
      if (rd) begin
        rd_cnt++;
        last_rd = cyc;
      end
      @(negedge clock);
      cyc++;
    end
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    check({tag, ".outputs"}, wr_cnt, N);
    check({tag, ".pops"}, rd_cnt, N);
    for (int i = 0; i < N; i++)
      check($sformatf("%s.px_r%0d_c%0d", tag, i / W, i % W), outs[i], exp_of(v, i / W, i % W));
    check({tag, ".pop_while_empty"}, v_rd_empty, 0);
    check({tag, ".rd_wr_same_cycle"}, v_both, 0);
    check({tag, ".push_while_full"}, v_wr_full, 0);
    if (v.mode == 0) check({tag, ".latency"}, v_lat, 0);
    if (v.mode == 1) begin
      check({tag, ".stall_cycles"}, stall, 50);
      check({tag, ".stall_hold"}, v_stall, 0);
    end
  endtask

  initial begin
    vec_t tbl [8];
    int rd_cnt, cyc;
    tbl[0] = '{0, 1'b0, 0, 100, 100, 0,   0, 0, 0, "uniform"};
    tbl[1] = '{0, 1'b0, 4,   0, 255, 0, 255, 4, 5, "vstep"};
    tbl[2] = '{1, 1'b0, 0,   0,   0, 0,   8, 2, 7, "ramp"};
    tbl[3] = '{0, 1'b1, 3,   0, 200, 0, 255, 3, 4, "hstep"};
    tbl[4] = '{0, 1'b0, 4,   0,  20, 0,  40, 4, 5, "vstep_small"};
    tbl[5] = '{0, 1'b0, 4,   0, 255, 1, 255, 4, 5, "vstep_backpressure"};
    tbl[6] = '{0, 1'b0, 4,   0, 255, 2, 255, 4, 5, "vstep_starve"};
    tbl[7] = '{1, 1'b0, 0,   0,   0, 3,   8, 2, 7, "ramp_random"};

    // reset state, with data offered so a leaky in_rd_en would show
    reset        = 1'b1;
    bus.in_dout  = 8'd55;
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    repeat (3) @(negedge clock);
    check("reset.in_rd_en", bus.in_rd_en, 0);
    check("reset.out_wr_en", bus.out_wr_en, 0);
    check("reset.out_din", bus.out_din, 0);
    bus.in_empty = 1'b1;
    reset = 1'b0;
    @(negedge clock);

    for (int t = 0; t < 8; t++) run_frame(tbl[t], tbl[t].name);

    // mid-frame async reset: stop with output 20 (255) held by out_full
    rd_cnt = 0;
    cyc    = 0;
    while (rd_cnt < 21 && cyc < 200) begin
      bus.in_dout  = DW'(pix_of(tbl[1], rd_cnt / W, rd_cnt % W));
      bus.in_empty = 1'b0;
      bus.out_full = 1'b0;
      #1;
      if (bus.in_rd_en) rd_cnt++;
      @(negedge clock);
      cyc++;
    end
    check("rst_mid.pops", rd_cnt, 21);
    bus.in_empty = 1'b0;
    bus.out_full = 1'b1;
    #1;
    check("rst_mid.pre_din", bus.out_din, exp_of(tbl[1], 2, 4));
    check("rst_mid.pre_wr_en", bus.out_wr_en, 0);
    reset = 1'b1;
    #1;
    check("rst_mid.async_din", bus.out_din, 0);
    check("rst_mid.async_rd_en", bus.in_rd_en, 0);
    check("rst_mid.async_wr_en", bus.out_wr_en, 0);
    repeat (2) @(negedge clock);
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    run_frame(tbl[1], "post_reset_vstep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
